// File: rtl/qr_codeword_extractor_pkg.sv
// Shared definitions for the version-1 QR codeword extractor: grid geometry,
// extractor state encoding, and module classification / grid addressing helpers.
package qr_pkg;

   localparam int MOD_SIZE      = 21;
   localparam int NUM_CODEWORDS = 26;
   localparam int GRID_BITS     = MOD_SIZE * MOD_SIZE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } ext_state_e;

   // Finder/separator/format areas, the timing row/column and the dark module.
   function automatic logic is_function_module(input logic [4:0] row, input logic [4:0] col);
      logic top, bottom, left, right;
      top    = (row <= 5'd8);
      bottom = (row >= 5'd13);
      left   = (col <= 5'd8);
      right  = (col >= 5'd13);
      return (top && left) || (top && right) || (bottom && left) ||
             (row == 5'd6) || (col == 5'd6);
   endfunction

   function automatic logic [8:0] grid_bit_index(input logic [4:0] row, input logic [4:0] col);
      return 9'(MOD_SIZE - 1) - 9'(row) + 9'(col) * 9'(MOD_SIZE);
   endfunction

endpackage

// File: rtl/qr_codeword_extractor_walker.sv
// Two-column zigzag position sequencer for a 21x21 grid. Starts at the bottom-right,
// steps right/left within a row, alternates direction per column pair, skips column 6.
module qr_zigzag_walker
   import qr_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       advance_i,
   input  logic       restart_i,
   output logic [4:0] row_o,
   output logic [4:0] col_o,
   output logic       is_data_o
);

   localparam logic [4:0] EDGE = 5'(MOD_SIZE - 1);

   logic [4:0] row_q, row_d;
   logic [4:0] col_q, col_d;
   logic       up_q, up_d;
   logic       right_q, right_d;
   logic       at_end_row;

   assign at_end_row = up_q ? (row_q == 5'd0) : (row_q == EDGE);

   always_comb begin
      row_d   = row_q;
      col_d   = col_q;
      up_d    = up_q;
      right_d = right_q;
      if (restart_i) begin
         row_d   = EDGE;
         col_d   = EDGE;
         up_d    = 1'b1;
         right_d = 1'b1;
      end else if (advance_i) begin
         if (right_q) begin
            col_d   = col_q - 5'd1;
            right_d = 1'b0;
         end else if (at_end_row) begin
            // Next pair; the pair after (8,7) is (5,4) because column 6 is timing.
            if (col_q != 5'd0) begin
               col_d   = (col_q == 5'd7) ? 5'd5 : col_q - 5'd1;
               up_d    = ~up_q;
               right_d = 1'b1;
            end
         end else begin
            row_d   = up_q ? row_q - 5'd1 : row_q + 5'd1;
            col_d   = col_q + 5'd1;
            right_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         row_q   <= '0;
         col_q   <= '0;
         up_q    <= 1'b1;
         right_q <= 1'b1;
      end else begin
         row_q   <= row_d;
         col_q   <= col_d;
         up_q    <= up_d;
         right_q <= right_d;
      end
   end

   assign row_o     = row_q;
   assign col_o     = col_q;
   assign is_data_o = ~is_function_module(row_q, col_q);

endmodule

// File: rtl/qr_codeword_extractor.sv
// Captures an unmasked version-1 QR grid, walks the data modules in zigzag order and
// streams the 26 packed codewords (MSB = first walked module) over valid/ready.
module qr_codeword_extractor
   import qr_pkg::*;
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 grid_valid,
   input  logic [GRID_BITS-1:0] grid_in,
   output logic [7:0]           cw_data,
   output logic                 cw_valid,
   input  logic                 cw_ready,
   output logic [4:0]           cw_index,
   output logic                 cw_last,
   output logic                 busy,
   output logic                 extract_done,
   output ext_state_e           dbg_state
);

   localparam logic [4:0] LAST_IDX = 5'(NUM_CODEWORDS - 1);

   ext_state_e           state_q, state_d;
   logic [GRID_BITS-1:0] grid_q, grid_d;
   logic [6:0]           shift_q, shift_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           cw_data_q, cw_data_d;
   logic                 cw_valid_q, cw_valid_d;
   logic [4:0]           cw_index_q, cw_index_d;
   logic                 cw_last_q, cw_last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic                 walk_advance, walk_restart, walk_is_data;
   logic [4:0]           walk_row, walk_col;
   logic                 cur_bit;

   qr_zigzag_walker u_walker (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .advance_i (walk_advance),
      .restart_i (walk_restart),
      .row_o     (walk_row),
      .col_o     (walk_col),
      .is_data_o (walk_is_data)
   );

   assign cur_bit = grid_q[grid_bit_index(walk_row, walk_col)];

   // Stream: cw_valid stays high with cw_data/cw_index/cw_last frozen until a cycle
   // with cw_valid && cw_ready; that edge is the transfer. Walk is frozen meanwhile.
   always_comb begin
      state_d      = state_q;
      grid_d       = grid_q;
      shift_d      = shift_q;
      bit_cnt_d    = bit_cnt_q;
      cw_data_d    = cw_data_q;
      cw_valid_d   = cw_valid_q;
      cw_index_d   = cw_index_q;
      cw_last_d    = cw_last_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      walk_advance = 1'b0;
      walk_restart = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grid_valid) begin
               grid_d       = grid_in;
               busy_d       = 1'b1;
               bit_cnt_d    = '0;
               cw_index_d   = '0;
               walk_restart = 1'b1;
               state_d      = ST_WALK;
            end
         end
         ST_WALK: begin
            walk_advance = 1'b1;
            if (walk_is_data) begin
               shift_d   = {shift_q[5:0], cur_bit};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  cw_data_d  = {shift_q, cur_bit};
                  cw_valid_d = 1'b1;
                  cw_last_d  = (cw_index_q == LAST_IDX);
                  state_d    = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (cw_ready) begin
               cw_valid_d = 1'b0;
               cw_last_d  = 1'b0;
               bit_cnt_d  = '0;
               if (cw_index_q == LAST_IDX) begin
                  cw_index_d = '0;
                  busy_d     = 1'b0;
                  done_d     = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  cw_index_d = cw_index_q + 5'd1;
                  state_d    = ST_WALK;
               end
            end
         end
         ST_DONE: begin
            cw_index_d = '0;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_IDLE;
         grid_q     <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         cw_data_q  <= '0;
         cw_valid_q <= 1'b0;
         cw_index_q <= '0;
         cw_last_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grid_q     <= grid_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         cw_data_q  <= cw_data_d;
         cw_valid_q <= cw_valid_d;
         cw_index_q <= cw_index_d;
         cw_last_q  <= cw_last_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign cw_data      = cw_data_q;
   assign cw_valid     = cw_valid_q;
   assign cw_index     = cw_index_q;
   assign cw_last      = cw_last_q;
   assign busy         = busy_q;
   assign extract_done = done_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_qr_codeword_extractor.sv
// Directed bench for qr_codeword_extractor: grids built from an independent placement
// model, codewords compared against an expected queue, stalls and mid-walk reset exercised.
module tb_qr_codeword_extractor;
   import qr_pkg::*;

   localparam int N      = 441;
   localparam int BUDGET = 3000;

   logic         clk_in     = 1'b0;
   logic         rst_in     = 1'b1;
   logic         grid_valid = 1'b0;
   logic [N-1:0] grid_in    = '0;
   logic         cw_ready   = 1'b0;
   logic [7:0]   cw_data;
   logic         cw_valid;
   logic [4:0]   cw_index;
   logic         cw_last;
   logic         busy;
   logic         extract_done;
   ext_state_e   dbg_state;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [7:0]   exp_q[$];
   int           walk_r[208];
   int           walk_c[208];
   logic [7:0]   hello[26] = '{8'h20, 8'h5B, 8'h0B, 8'h78, 8'hD1, 8'h72, 8'hDC, 8'h4D,
                               8'h43, 8'h40, 8'hEC, 8'h11, 8'hEC, 8'h11, 8'hEC, 8'h11,
                               8'hC4, 8'h23, 8'h27, 8'h77, 8'hEB, 8'hD7, 8'hE7, 8'hE2,
                               8'h5D, 8'h17};

   qr_codeword_extractor dut (
      .clk_in       (clk_in),
      .rst_in       (rst_in),
      .grid_valid   (grid_valid),
      .grid_in      (grid_in),
      .cw_data      (cw_data),
      .cw_valid     (cw_valid),
      .cw_ready     (cw_ready),
      .cw_index     (cw_index),
      .cw_last      (cw_last),
      .busy         (busy),
      .extract_done (extract_done),
      .dbg_state    (dbg_state)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_func(input int y, input int x);
      return (y < 9 && x < 9) || (y < 9 && x > 12) || (y > 12 && x < 9) || y == 6 || x == 6;
   endfunction

   function automatic int gidx(input int y, input int x);
      return (20 - y) + x * 21;
   endfunction

   // Reference placement order: right column index steps by 2, skipping the timing column.
   task automatic build_walk();
      int n;
      int x;
      int y;
      bit up;
      n = 0;
      for (int right = 20; right >= 1; right -= 2) begin
         if (right == 6) right = 5;
         up = (((right + 1) & 2) == 0);
         for (int vert = 0; vert < 21; vert++) begin
            for (int j = 0; j < 2; j++) begin
               x = right - j;
               y = up ? 20 - vert : vert;
               if (!is_func(y, x) && n < 208) begin
                  walk_r[n] = y;
                  walk_c[n] = x;
                  n++;
               end
            end
         end
      end
      check("model_walk_len", n, 208);
   endtask

   function automatic logic [N-1:0] func_grid();
      logic [N-1:0] g;
      g = '0;
      for (int y = 0; y < 21; y++)
         for (int x = 0; x < 21; x++)
            if (is_func(y, x)) g[gidx(y, x)] = 1'b1;
      return g;
   endfunction

   function automatic logic [N-1:0] hello_grid();
      logic [N-1:0] g;
      logic [7:0]   b;
      g = '0;
      for (int i = 0; i < 208; i++) begin
         b = hello[i / 8];
         g[gidx(walk_r[i], walk_c[i])] = b[7 - (i % 8)];
      end
      return g;
   endfunction

   task automatic push_fill(input logic [7:0] v);
      for (int k = 0; k < 26; k++) exp_q.push_back(v);
   endtask

   task automatic push_one_hot(input int pos, input logic [7:0] v);
      for (int k = 0; k < 26; k++) exp_q.push_back((k == pos) ? v : 8'h00);
   endtask

   task automatic push_hello();
      for (int k = 0; k < 26; k++) exp_q.push_back(hello[k]);
   endtask

   // mode 0: always ready; 1: 5-cycle stall on cw3 then random; 2: always ready plus a
   // stray grid_valid while busy.
   task automatic run_grid(input string name, input logic [N-1:0] g, input int mode);
      int         cyc;
      int         got;
      int         stall_cnt;
      int         early;
      bit         first;
      bit         stalled;
      bit         rdy;
      logic [7:0] hold_d;
      logic [4:0] hold_i;
      logic [7:0] exp;
      cyc = 0; got = 0; stall_cnt = 0; early = 0; first = 1'b1; stalled = 1'b0;
      hold_d = '0; hold_i = '0;
      @(negedge clk_in);
      grid_in    = g;
      grid_valid = 1'b1;
      cw_ready   = (mode != 1);
      @(negedge clk_in);
      grid_valid = 1'b0;
      cyc = 1;
      check({name, "_busy_after_capture"}, busy, 1);
      while (got < 26 && cyc < BUDGET) begin
         grid_valid = (mode == 2 && cyc == 20);
         if (mode == 2 && cyc == 20) grid_in = ~g;
         if (extract_done) early++;
         if (cw_valid) begin
            if (first) begin
               if (mode != 1) check({name, "_first_latency"}, cyc, 9);
               first = 1'b0;
            end
            if (stalled) begin
               check({name, "_stall_data"}, cw_data, hold_d);
               check({name, "_stall_index"}, cw_index, hold_i);
            end
            if (mode == 1 && got == 3 && stall_cnt < 5) begin
               rdy = 1'b0;
               stall_cnt++;
            end else if (mode == 1 && got > 3) begin
               rdy = 1'($urandom_range(0, 1));
            end else begin
               rdy = 1'b1;
            end
            cw_ready = rdy;
            if (rdy) begin
               exp = exp_q.pop_front();
               check($sformatf("%s_cw%0d_data", name, got), cw_data, exp);
               check($sformatf("%s_cw%0d_index", name, got), cw_index, got);
               check($sformatf("%s_cw%0d_last", name, got), cw_last, (got == 25));
               got++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               hold_d  = cw_data;
               hold_i  = cw_index;
            end
         end else begin
            cw_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         @(negedge clk_in);
         cyc++;
      end
      grid_valid = 1'b0;
      check({name, "_codewords_received"}, got, 26);
      check({name, "_early_done"}, early, 0);
      check({name, "_extract_done"}, extract_done, 1);
      check({name, "_busy_at_done"}, busy, 0);
      @(negedge clk_in);
      check({name, "_done_one_cycle"}, extract_done, 0);
      check({name, "_idle_after"}, dbg_state, ST_IDLE);
      check({name, "_exp_q_drained"}, exp_q.size(), 0);
      exp_q.delete();
      cw_ready = 1'b0;
   endtask

   task automatic abort_mid_walk(input logic [N-1:0] g);
      int cyc;
      cyc = 0;
      @(negedge clk_in);
      grid_in    = g;
      grid_valid = 1'b1;
      cw_ready   = 1'b1;
      @(negedge clk_in);
      grid_valid = 1'b0;
      while (!(cw_valid && cw_index == 5'd7) && cyc < BUDGET) begin
         @(negedge clk_in);
         cyc++;
      end
      check("abort_reached_cw7", {cw_valid, cw_index}, {1'b1, 5'd7});
      #2 rst_in = 1'b1;
      #1;
      check("abort_cw_valid", cw_valid, 0);
      check("abort_cw_index", cw_index, 0);
      check("abort_cw_data", cw_data, 0);
      check("abort_cw_last", cw_last, 0);
      check("abort_busy", busy, 0);
      check("abort_state", dbg_state, ST_IDLE);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("abort_stays_quiet", {cw_valid, busy, extract_done}, 0);
   endtask

   initial begin
      logic [N-1:0] g;
      build_walk();
      rst_in = 1'b1;
      repeat (3) @(negedge clk_in);
      check("rst_cw_data", cw_data, 0);
      check("rst_cw_valid", cw_valid, 0);
      check("rst_cw_index", cw_index, 0);
      check("rst_cw_last", cw_last, 0);
      check("rst_busy", busy, 0);
      check("rst_extract_done", extract_done, 0);
      check("rst_state", dbg_state, ST_IDLE);
      rst_in = 1'b0;
      @(negedge clk_in);

      push_fill(8'h00);
      run_grid("zeros", '0, 0);

      push_fill(8'hFF);
      run_grid("ones", '1, 0);

      push_fill(8'h00);
      run_grid("func_only", func_grid(), 0);

      g = '0;
      g[gidx(20, 20)] = 1'b1;
      push_one_hot(0, 8'h80);
      run_grid("bit_r20c20", g, 0);

      g = '0;
      g[gidx(17, 19)] = 1'b1;
      push_one_hot(0, 8'h01);
      run_grid("bit_r17c19", g, 0);

      // (9,4) is walk position 185: codeword 23, second bit.
      g = '0;
      g[gidx(9, 4)] = 1'b1;
      push_one_hot(23, 8'h40);
      run_grid("bit_r9c4", g, 0);

      push_hello();
      run_grid("hello", hello_grid(), 0);

      push_hello();
      run_grid("hello_bp", hello_grid(), 1);

      abort_mid_walk(hello_grid());

      push_hello();
      run_grid("hello_restart", hello_grid(), 0);

      push_hello();
      run_grid("hello_stray_gv", hello_grid(), 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
